// File: rtl/transaccion_pkg.sv
// Shared types and constants for the dispatch path.
// State codes, widths, destination slice, default thresholds.
package transaccion_pkg;

  localparam int DATA_W   = 12;
  localparam int N_FIFO   = 4;
  localparam int UMBRAL_W = 3;
  localparam int DEST_W   = $clog2(N_FIFO);
  localparam int DEST_HI  = DATA_W - 1;
  localparam int DEST_LO  = DATA_W - DEST_W;

  localparam logic [UMBRAL_W-1:0] UMBRAL_BAJO_DEF = 3'd1;
  localparam logic [UMBRAL_W-1:0] UMBRAL_ALTO_DEF = 3'd6;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } estado_t;

  function automatic logic umbrales_validos(
    input logic [UMBRAL_W-1:0] bajo,
    input logic [UMBRAL_W-1:0] alto
  );
    return (alto != '0) && (bajo < alto);
  endfunction

endpackage

// File: rtl/controlador_despacho_if.sv
// Main-FIFO / blue-FIFO bus of the dispatch controller.
// master: dispatcher side; slave: FIFO side.
interface controlador_despacho_if;
  import transaccion_pkg::*;

  logic              main_empty;
  logic [DATA_W-1:0] main_data;
  logic              pop_main;
  logic [N_FIFO-1:0] azul_almost_full;
  logic [N_FIFO-1:0] azul_full;
  logic [N_FIFO-1:0] push_azul;
  logic [DATA_W-1:0] data_azul;

  modport master (
    input  main_empty,
    input  main_data,
    input  azul_almost_full,
    input  azul_full,
    output pop_main,
    output push_azul,
    output data_azul
  );

  modport slave (
    output main_empty,
    output main_data,
    output azul_almost_full,
    output azul_full,
    input  pop_main,
    input  push_azul,
    input  data_azul
  );

endinterface

// File: rtl/selector_destino.sv
// Head-word destination decode and pop qualification.
// in: habilitar, main_empty, main_data, azul_almost_full; out: destino, pop.
module selector_destino
  import transaccion_pkg::*;
(
  input  logic              habilitar,
  input  logic              main_empty,
  input  logic [DATA_W-1:0] main_data,
  input  logic [N_FIFO-1:0] azul_almost_full,
  output logic [N_FIFO-1:0] destino,
  output logic              pop
);

  logic [DEST_W-1:0] d;

  assign d = main_data[DEST_HI:DEST_LO];

  always_comb begin
    destino    = '0;
    destino[d] = 1'b1;
  end

  // A blocked head stalls everything behind it.
  assign pop = habilitar
             && !main_empty
             && !azul_almost_full[d];

endmodule

// File: rtl/controlador_despacho.sv
// Dispatch controller: main FIFO -> four blue FIFOs, init/idle FSM.
// clk, reset, init, umbral_*_in; bus (master); umbral_*, idle, error, estado.
module controlador_despacho
  import transaccion_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [UMBRAL_W-1:0] umbral_bajo_in,
  input  logic [UMBRAL_W-1:0] umbral_alto_in,
  controlador_despacho_if.master bus,
  output logic [UMBRAL_W-1:0] umbral_bajo,
  output logic [UMBRAL_W-1:0] umbral_alto,
  output logic                idle,
  output logic                error,
  output logic [2:0]          estado
);

  estado_t           st, st_nx;
  logic              err_cond;
  logic              push_pend;
  logic              habilitar;
  logic              pop;
  logic [N_FIFO-1:0] destino;
  logic [N_FIFO-1:0] push_q;
  logic [DATA_W-1:0] data_q;

  assign push_pend = |push_q;
  assign err_cond  = |(push_q & bus.azul_full);

  // Error wins: no new word is taken in the cycle it is detected.
  assign habilitar = (st == ST_ACTIVE)
                   && !init
                   && !err_cond;

  selector_destino u_sel (
    .habilitar        (habilitar),
    .main_empty       (bus.main_empty),
    .main_data        (bus.main_data),
    .azul_almost_full (bus.azul_almost_full),
    .destino          (destino),
    .pop              (pop)
  );

  assign bus.pop_main  = pop;
  assign bus.push_azul = push_q;
  assign bus.data_azul = data_q;

  assign estado = st;
  assign idle   = (st == ST_IDLE);
  assign error  = (st == ST_ERROR);

  always_comb begin
    st_nx = st;
    if (err_cond) begin
      st_nx = ST_ERROR;
    end else begin
      unique case (st)
        ST_RESET: begin
          if (init) st_nx = ST_INIT;
        end
        ST_INIT: begin
          // Registers hold the last init-high sample here.
          if (!init) begin
            if (umbrales_validos(umbral_bajo, umbral_alto))
              st_nx = ST_IDLE;
            else
              st_nx = ST_ERROR;
          end
        end
        ST_IDLE: begin
          if (init)
            st_nx = ST_INIT;
          else if (!bus.main_empty)
            st_nx = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          // Leave only once the in-flight push has drained.
          if (init) begin
            if (!push_pend) st_nx = ST_INIT;
          end else if (bus.main_empty && !push_pend) begin
            st_nx = ST_IDLE;
          end
        end
        ST_ERROR: begin
          if (init) st_nx = ST_INIT;
        end
        default: st_nx = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= ST_RESET;
      push_q      <= '0;
      data_q      <= '0;
      umbral_bajo <= UMBRAL_BAJO_DEF;
      umbral_alto <= UMBRAL_ALTO_DEF;
    end else begin
      st     <= st_nx;
      push_q <= pop ? destino : '0;
      if (pop) data_q <= bus.main_data;
      if (st == ST_INIT && init) begin
        umbral_bajo <= umbral_bajo_in;
        umbral_alto <= umbral_alto_in;
      end
    end
  end

endmodule

// File: tb/tb_controlador_despacho.sv
// Self-checking bench for controlador_despacho.
// Directed scenarios plus random traffic against a cycle reference model.
module tb_controlador_despacho;
  import transaccion_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [2:0] ub_in;
  logic [2:0] ua_in;
  logic [2:0] ub;
  logic [2:0] ua;
  logic       idle;
  logic       error;
  logic [2:0] estado;

  always #5 clk = ~clk;

  controlador_despacho_if bus ();

  controlador_despacho dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .umbral_bajo_in (ub_in),
    .umbral_alto_in (ua_in),
    .bus            (bus),
    .umbral_bajo    (ub),
    .umbral_alto    (ua),
    .idle           (idle),
    .error          (error),
    .estado         (estado)
  );

  typedef struct {
    logic [3:0]  p;
    logic [11:0] d;
  } ev_t;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          m_st;
  logic [3:0]  m_push;
  logic [11:0] m_data;
  logic [2:0]  m_b;
  logic [2:0]  m_a;
  logic [11:0] q[$];
  ev_t         obs[$];
  int          dut_pops;
  logic        last_pop;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_defaults();
    m_st   = 0;
    m_push = 4'b0000;
    m_data = 12'h000;
    m_b    = 3'd1;
    m_a    = 3'd6;
  endtask

  task automatic cycle(
    input logic       rst,
    input logic       ini,
    input logic [2:0] b,
    input logic [2:0] a,
    input logic [3:0] af,
    input logic [3:0] full
  );
    logic        e_pop;
    logic        err;
    logic        ne;
    logic [1:0]  d;
    logic [11:0] head;
    int          nx;
    ne   = (q.size() != 0);
    head = ne ? q[0] : 12'h000;
    d    = head[11:10];
    reset = rst;
    init  = ini;
    ub_in = b;
    ua_in = a;
    bus.azul_almost_full = af;
    bus.azul_full        = full;
    bus.main_empty       = !ne;
    bus.main_data        = head;
    err   = |(m_push & full);
    e_pop = (m_st == 3) && ne && !af[d] && !ini && !err;
    last_pop = e_pop;
    @(negedge clk);
    check("pop_main", 32'(bus.pop_main), 32'(e_pop));
    check("push_azul", 32'(bus.push_azul), 32'(m_push));
    check("data_azul", 32'(bus.data_azul), 32'(m_data));
    check("estado", 32'(estado), m_st);
    check("idle", 32'(idle), 32'(m_st == 2));
    check("error", 32'(error), 32'(m_st == 4));
    check("umbral_bajo", 32'(ub), 32'(m_b));
    check("umbral_alto", 32'(ua), 32'(m_a));
    if (bus.pop_main) dut_pops++;
    if (bus.push_azul != 4'b0000)
      obs.push_back('{bus.push_azul, bus.data_azul});
    @(posedge clk);
    if (e_pop) void'(q.pop_front());
    if (rst) begin
      model_defaults();
    end else begin
      nx = m_st;
      if (err) nx = 4;
      else if (m_st == 0) begin
        if (ini) nx = 1;
      end else if (m_st == 1) begin
        if (!ini) nx = (m_a != 0 && m_b < m_a) ? 2 : 4;
      end else if (m_st == 2) begin
        if (ini) nx = 1;
        else if (ne) nx = 3;
      end else if (m_st == 3) begin
        if (ini) begin
          if (m_push == 4'b0000) nx = 1;
        end else if (!ne && m_push == 4'b0000) begin
          nx = 2;
        end
      end else begin
        if (ini) nx = 1;
      end
      if (m_st == 1 && ini) begin
        m_b = b;
        m_a = a;
      end
      m_push = e_pop ? (4'b0001 << d) : 4'b0000;
      if (e_pop) m_data = head;
      m_st = nx;
    end
    #1;
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 1'b0, 3'd0, 3'd0, 4'h0, 4'h0);
  endtask

  task automatic init_seq(input logic [2:0] b, input logic [2:0] a);
    cycle(1'b0, 1'b1, b, a, 4'h0, 4'h0);
    cycle(1'b0, 1'b1, b, a, 4'h0, 4'h0);
    cycle(1'b0, 1'b0, 3'd0, 3'd0, 4'h0, 4'h0);
    cycle(1'b0, 1'b0, 3'd0, 3'd0, 4'h0, 4'h0);
  endtask

  task automatic check_obs(string tag, int i, logic [3:0] p, logic [11:0] d);
    if (i < obs.size()) begin
      check(tag, 32'(obs[i].p), 32'(p));
      check(tag, 32'(obs[i].d), 32'(d));
    end
  endtask

  initial begin
    int         init_left;
    logic [2:0] rb;
    logic [2:0] ra;
    reset = 1'b1;
    init  = 1'b0;
    ub_in = 3'd0;
    ua_in = 3'd0;
    bus.main_empty       = 1'b1;
    bus.main_data        = 12'h000;
    bus.azul_almost_full = 4'h0;
    bus.azul_full        = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    model_defaults();
    dut_pops = 0;

    cycle(1'b1, 1'b0, 3'd0, 3'd0, 4'h0, 4'h0);
    cycle(1'b0, 1'b1, 3'd2, 3'd5, 4'h0, 4'h0);
    cycle(1'b0, 1'b1, 3'd2, 3'd5, 4'h0, 4'h0);
    idle_cyc(2);
    check("init_bajo", 32'(ub), 32'd2);
    check("init_alto", 32'(ua), 32'd5);
    check("init_idle", 32'(idle), 32'd1);

    dut_pops = 0;
    init_seq(3'd5, 3'd3);
    check("bad_err", 32'(error), 32'd1);
    init_seq(3'd3, 3'd3);
    check("eq_err", 32'(error), 32'd1);
    init_seq(3'd0, 3'd0);
    check("zero_err", 32'(error), 32'd1);
    init_seq(3'd2, 3'd5);
    check("reinit_err", 32'(error), 32'd0);
    check("reinit_idle", 32'(idle), 32'd1);
    check("bad_no_pop", 32'(dut_pops), 32'd0);

    obs.delete();
    dut_pops = 0;
    q.push_back(12'h123);
    q.push_back(12'h456);
    q.push_back(12'h8AB);
    q.push_back(12'hCDE);
    idle_cyc(10);
    check("burst_pops", 32'(dut_pops), 32'd4);
    check("burst_n", 32'(obs.size()), 32'd4);
    check_obs("burst0", 0, 4'b0001, 12'h123);
    check_obs("burst1", 1, 4'b0010, 12'h456);
    check_obs("burst2", 2, 4'b0100, 12'h8AB);
    check_obs("burst3", 3, 4'b1000, 12'hCDE);
    check("burst_idle", 32'(idle), 32'd1);

    obs.delete();
    q.push_back(12'h8AB);
    q.push_back(12'h123);
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 1'b0, 3'd0, 3'd0, 4'b0100, 4'h0);
    check("af_stall", 32'(obs.size()), 32'd0);
    idle_cyc(8);
    check("af_n", 32'(obs.size()), 32'd2);
    check_obs("af0", 0, 4'b0100, 12'h8AB);
    check_obs("af1", 1, 4'b0001, 12'h123);

    dut_pops = 0;
    q.push_back(12'h123);
    q.push_back(12'h456);
    q.push_back(12'h8AB);
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 1'b0, 3'd0, 3'd0, 4'h0,
            (m_push == 4'b0010) ? 4'b0010 : 4'b0000);
    check("full_err", 32'(error), 32'd1);
    check("full_estado", 32'(estado), 32'd4);
    check("full_pops", 32'(dut_pops), 32'd2);
    init_seq(3'd2, 3'd5);
    check("full_clear", 32'(error), 32'd0);
    idle_cyc(6);

    q.push_back(12'hCDE);
    q.push_back(12'h456);
    last_pop = 1'b0;
    for (int k = 0; k < 20 && !last_pop; k++)
      cycle(1'b0, 1'b0, 3'd0, 3'd0, 4'h0, 4'h0);
    check("rst_pop_seen", 32'(last_pop), 32'd1);
    cycle(1'b1, 1'b0, 3'd0, 3'd0, 4'h0, 4'h0);
    check("rst_push", 32'(bus.push_azul), 32'd0);
    check("rst_data", 32'(bus.data_azul), 32'd0);
    check("rst_estado", 32'(estado), 32'd0);
    check("rst_bajo", 32'(ub), 32'd1);
    check("rst_alto", 32'(ua), 32'd6);
    idle_cyc(2);

    init_left = 0;
    rb = 3'd2;
    ra = 3'd5;
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic       ini;
      logic [3:0] af;
      logic [3:0] full;
      if (init_left == 0) begin
        if ($urandom_range(0, 99) == 0
            || ((m_st == 0 || m_st == 4)
                && $urandom_range(0, 9) == 0)) begin
          init_left = $urandom_range(1, 3);
          if ($urandom_range(0, 3) != 0) begin
            ra = 3'($urandom_range(1, 7));
            rb = 3'($urandom_range(0, 32'(ra) - 1));
          end else begin
            ra = 3'($urandom);
            rb = 3'($urandom);
          end
        end
      end
      ini = (init_left > 0);
      if (init_left > 0) init_left--;
      if (q.size() < 4 && $urandom_range(0, 1) == 1)
        q.push_back(12'($urandom));
      af = 4'h0;
      for (int j = 0; j < 4; j++)
        af[j] = ($urandom_range(0, 3) == 0);
      full = ($urandom_range(0, 199) == 0) ? 4'($urandom) : 4'h0;
      r = ($urandom_range(0, 499) == 0);
      cycle(r, ini, rb, ra, af, full);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/controlador_despacho.md
# controlador_despacho

Dispatch controller between the main input FIFO and the four blue FIFOs of the transaction layer. It drains 12-bit words from the main FIFO and routes each to the blue FIFO selected by its destination field. It applies back-pressure from the blue FIFOs' almost-full flags and owns the init/idle state machine. It also latches and distributes the umbral_bajo and umbral_alto thresholds to all FIFOs.

## Interface
- DATA_W, 12, word width; bits [DATA_W-1:DATA_W-2] are the destination field
- N_FIFO, 4, number of blue FIFOs (destination field is log2(N_FIFO) bits)
- UMBRAL_W, 3, threshold width
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- init  in  1  configuration request; thresholds are sampled while high
- umbral_bajo_in  in  UMBRAL_W  almost-empty threshold to latch
- umbral_alto_in  in  UMBRAL_W  almost-full threshold to latch
- main_empty  in  1  main FIFO empty
- main_data  in  DATA_W  main FIFO head word; first-word-fall-through, valid when !main_empty
- azul_almost_full  in  N_FIFO  per-blue-FIFO almost-full
- azul_full  in  N_FIFO  per-blue-FIFO full
- pop_main  out  1  combinational pop of main FIFO head
- push_azul  out  N_FIFO  registered one-hot push
- data_azul  out  DATA_W  registered word accompanying push_azul
- umbral_bajo  out  UMBRAL_W  registered threshold to all FIFOs
- umbral_alto  out  UMBRAL_W  registered threshold to all FIFOs
- idle  out  1  registered, high in IDLE
- error  out  1  registered, sticky error flag
- estado  out  3  registered state code

## Operation
- States and codes: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- RESET:
  - If init=1, go to INIT.
  - Otherwise stay in RESET; no dispatch.
- INIT:
  - Every cycle, umbral_bajo and umbral_alto load from the *_in inputs.
  - When init falls, check the value latched in the last init-high cycle.
  - Invalid (umbral_alto==0 or umbral_bajo>=umbral_alto): go to ERROR.
  - Valid: go to IDLE.
- IDLE:
  - If init=1, go to INIT.
  - Else if !main_empty, go to ACTIVE.
- ACTIVE dispatch condition, all required in the same cycle:
  - d = main_data[DATA_W-1:DATA_W-2]
  - pop_main=1 when state==ACTIVE, !main_empty, !azul_almost_full[d] and init==0.
  - A blocked head word stalls the whole stream; there is no reordering and no skipping past it.
- Each pop registers one word: next cycle push_azul=1<<d and data_azul=main_data. Otherwise push_azul=0 and data_azul holds its value.
- Leaving ACTIVE, checked in this order:
  - Error condition (any cycle, not only ACTIVE): a registered push to FIFO i while azul_full[i]=1. This sets error=1 and goes to ERROR.
  - init=1 goes to INIT only after the in-flight push (if any) completes. pop_main is held 0 meanwhile.
  - main_empty with no push pending goes to IDLE.
- ERROR:
  - error=1, pop_main=0, push_azul=0.
  - Exits only via reset, or init=1 to INIT. Entering INIT clears error.
- Reset values:
  - estado=RESET, pop_main=0, push_azul=0, data_azul=0, idle=0, error=0.
  - umbral_bajo=1, umbral_alto=6.
- Reset mid-transfer: a pending push is discarded and nothing is pushed in the next cycle.

## Timing
- pop_main is combinational from registered state and current inputs, in the same cycle the head is consumed.
- Push latency is 1 cycle after pop_main. Throughput is 1 word/cycle when unblocked.
- The almost-full threshold must leave at least 1 entry of slack for the in-flight push. A push onto a truly full FIFO is an error.
- Threshold outputs change only in INIT, with 1-cycle latency from the *_in inputs.
- idle, error and estado reflect the state register with no extra delay.
- Simultaneous init and error condition: error wins for that cycle. init then exits ERROR on the next cycle if still high.

## Structure
- Shared package (transaccion_pkg) holds:
  - state encodings
  - DATA_W, N_FIFO, UMBRAL_W
  - default threshold constants (1, 6)
  - the destination-field slice positions
- One natural sub-module, `selector_destino`, which does:
  - destination decode to a one-hot value
  - almost-full mux
  - pop qualification
- The FSM and output registers stay in the top.

## Test plan
- Reset, init=1 with bajo=2/alto=5 for 2 cycles, then init=0 -> umbral_bajo=2, umbral_alto=5, estado=IDLE, idle=1.
- Init with bajo=5/alto=3 -> ERROR, error=1, no pop. A second init with valid values -> error=0, IDLE.
- Push 0x123, 0x456, 0x8AB, 0xCDE into main -> pop on 4 consecutive cycles. push_azul is 0001, 0010, 0100, 1000 one cycle later with matching data_azul. Then IDLE.
- azul_almost_full[2]=1 with head 0x8AB and 0x123 behind it -> pop_main=0 until the flag drops, then 0x8AB is pushed to FIFO 2 before 0x123 goes to FIFO 0.
- Force azul_full[1]=1 in the cycle of a registered push to FIFO 1 -> error=1, estado=4, no further pops.
- Assert reset the cycle after a pop -> push_azul=0 next cycle, all outputs at reset values, umbral_bajo=1, umbral_alto=6.
